// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// VGA test-pattern generator for the 25 MHz pixel domain. Sits between the
// hvsync timing block and the VGA pins. Produces one of four patterns,
// selected once per frame: colour bars, checkerboard, grey gradient and
// scrolling colour bars. Colour, data-enable and syncs are all registered
// together, so every output changes on the same clock edge, one cycle after
// the pixel position that produced it.
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   reset        in   synchronous, active-high reset
//   mode_sel     in   requested pattern (0 bars, 1 checker, 2 gradient,
//                     3 scrolling bars), sampled at frame start only
//   hsync_in     in   horizontal sync from hvsync
//   vsync_in     in   vertical sync from hvsync
//   display_on   in   active-video flag from hvsync
//   hpos, vpos   in   current pixel position (10 bits each)
//   hsync_out    out  hsync_in delayed one cycle
//   vsync_out    out  vsync_in delayed one cycle
//   de_out       out  display_on delayed one cycle
//   vga_r/g/b    out  pixel colour, COLOR_W bits per channel
//   mode_active  out  pattern currently displayed
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int   H_ACTIVE     = 640,
    parameter int   V_ACTIVE     = 480,
    parameter int   COLOR_W      = 4,
    parameter int   NUM_BARS     = 8,
    parameter int   CHECK_SHIFT  = 5,
    parameter int   SCROLL_SHIFT = 4,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode_sel,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic [1:0]         mode_active
);

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_CHECK  = 2'd1,
        MODE_GRAD   = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_t;

    localparam int BAR_W  = H_ACTIVE / NUM_BARS;
    localparam int GRAD_W = H_ACTIVE >> COLOR_W;

    localparam logic [9:0]         H_END      = 10'(H_ACTIVE);
    localparam logic [9:0]         V_END      = 10'(V_ACTIVE);
    localparam logic [9:0]         BAR_W_LAST = 10'(BAR_W - 1);
    localparam logic [9:0]         GRAD_LAST  = 10'(GRAD_W - 1);
    localparam logic [3:0]         LAST_BAR   = 4'(NUM_BARS - 1);
    localparam logic [COLOR_W-1:0] LEVEL_MAX  = '1;

    // Registered state
    logic [3:0]              bar_q;        // bar index of the next pixel
    logic [9:0]              bar_pix_q;    // position inside that bar
    logic [COLOR_W-1:0]      lvl_q;        // gradient level of the next pixel
    logic [9:0]              lvl_pix_q;    // position inside that level
    logic [SCROLL_SHIFT-1:0] frame_cnt_q;
    logic [3:0]              scroll_idx_q;

    // Current-pixel view
    logic               frame_start;
    logic               line_start;
    logic               blank;
    mode_t              mode_cur;
    logic [3:0]         bar_cur;
    logic [9:0]         bar_pix_cur;
    logic [COLOR_W-1:0] lvl_cur;
    logic [9:0]         lvl_pix_cur;
    logic [2:0]         bar_code;
    logic               chk_on;

    // Next-state and colour
    logic [3:0]         bar_d;
    logic [9:0]         bar_pix_d;
    logic [COLOR_W-1:0] lvl_d;
    logic [9:0]         lvl_pix_d;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    assign frame_start = (hpos == '0) && (vpos == '0);
    assign line_start  = (hpos == '0);
    assign blank       = !display_on || (hpos >= H_END) || (vpos >= V_END);

    // The latched mode only updates on the edge that closes the frame-start
    // cycle, so pixel (0,0) takes mode_sel directly.
    assign mode_cur = mode_t'(frame_start ? mode_sel : mode_active);

    // Colour code 7 - (k mod 8) is simply the inverted low three bits of k.
    assign bar_code = ~bar_cur[2:0];
    assign chk_on   = hpos[CHECK_SHIFT] ^ vpos[CHECK_SHIFT];

    // Pixel counters replace hpos/BAR_W and hpos/GRAD_W. The registers hold
    // the values for the following pixel; at hpos==0 they are overridden so
    // each line starts cleanly even after a mid-line reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        bar_cur     = bar_q;
        bar_pix_cur = bar_pix_q;
        lvl_cur     = lvl_q;
        lvl_pix_cur = lvl_pix_q;
        if (line_start) begin
            bar_cur     = (mode_cur == MODE_SCROLL) ? scroll_idx_q : '0;
            bar_pix_cur = '0;
            lvl_cur     = '0;
            lvl_pix_cur = '0;
        end

        bar_d     = bar_cur;
        bar_pix_d = bar_pix_cur + 10'd1;
        if (bar_pix_cur == BAR_W_LAST) begin
            bar_pix_d = '0;
            if (bar_cur != LAST_BAR) begin
                bar_d = bar_cur + 4'd1;
            end else if (mode_cur == MODE_SCROLL) begin
                bar_d = '0;                    // scrolling bars wrap around
            end
        end

        lvl_d     = lvl_cur;
        lvl_pix_d = lvl_pix_cur + 10'd1;
        if (lvl_pix_cur == GRAD_LAST) begin
            lvl_pix_d = '0;
            if (lvl_cur != LEVEL_MAX) begin
                lvl_d = lvl_cur + COLOR_W'(1);
            end
        end
    end

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (!blank) begin
            unique case (mode_cur)
                MODE_BARS, MODE_SCROLL: begin
                    pix_r = {COLOR_W{bar_code[2]}};
                    pix_g = {COLOR_W{bar_code[1]}};
                    pix_b = {COLOR_W{bar_code[0]}};
                end
                MODE_CHECK: begin
                    pix_r = {COLOR_W{chk_on}};
                    pix_g = {COLOR_W{chk_on}};
                    pix_b = {COLOR_W{chk_on}};
                end
                MODE_GRAD: begin
                    pix_r = lvl_cur;
                    pix_g = lvl_cur;
                    pix_b = lvl_cur;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            bar_q        <= '0;
            bar_pix_q    <= '0;
            lvl_q        <= '0;
            lvl_pix_q    <= '0;
            frame_cnt_q  <= '0;
            scroll_idx_q <= '0;
            mode_active  <= 2'd0;
            hsync_out    <= SYNC_IDLE;
            vsync_out    <= SYNC_IDLE;
            de_out       <= 1'b0;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
        end else begin
            bar_q     <= bar_d;
            bar_pix_q <= bar_pix_d;
            lvl_q     <= lvl_d;
            lvl_pix_q <= lvl_pix_d;

            if (frame_start) begin
                mode_active <= mode_sel;
                frame_cnt_q <= frame_cnt_q + SCROLL_SHIFT'(1);
                if (frame_cnt_q == '1) begin
                    scroll_idx_q <= (scroll_idx_q == LAST_BAR) ? '0 : scroll_idx_q + 4'd1;
                end
            end

            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            de_out    <= display_on;
            vga_r     <= pix_r;
            vga_g     <= pix_g;
            vga_b     <= pix_b;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Directed bench for vga_pattern_gen. The stimulus side walks pixel
// positions and, for each driven pixel, pushes the expected registered
// output onto a scoreboard queue; selected pixels carry hand-computed colour
// and mode values. A separate monitor pops one entry per clock edge and
// compares it against the DUT outputs shortly after the edge.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam int DE_NORMAL = 0;
    localparam int DE_ON     = 1;
    localparam int DE_OFF    = 2;

    typedef struct {
        bit          chk;
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic [1:0]  mode;
        string       name;
    } exp_t;

    typedef struct {
        int          h;
        logic [11:0] rgb;
        logic [1:0]  mode;
        string       name;
    } cp_t;

    logic       clk;
    logic       reset;
    logic [1:0] mode_sel;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync_out;
    logic       vsync_out;
    logic       de_out;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic [1:0] mode_active;

    exp_t sb_q[$];
    cp_t  cp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   sw_h     = -1;
    logic [1:0] sw_mode = 2'd0;

    vga_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .de_out     (de_out),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .mode_active(mode_active)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: the entry pushed before this edge describes what the DUT
    // registers on this edge.
    always @(posedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            #1;
            if (e.chk) begin
                check({e.name, ".rgb"},  32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                check({e.name, ".de"},   32'(de_out),      32'(e.de));
                check({e.name, ".hs"},   32'(hsync_out),   32'(e.hs));
                check({e.name, ".vs"},   32'(vsync_out),   32'(e.vs));
                check({e.name, ".mode"}, 32'(mode_active), 32'(e.mode));
            end
        end
    end

    task automatic cp(input int h, input logic [11:0] rgb, input logic [1:0] mode, input string name);
        cp_t c;
        c.h = h; c.rgb = rgb; c.mode = mode; c.name = name;
        cp_q.push_back(c);
    endtask

    // Hold reset for n pixels starting at (h0, v) while feeding inputs that
    // would otherwise produce visible output.
    task automatic reset_pix(input int v, input int h0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(negedge clk);
            reset      = 1'b1;
            hpos       = 10'(h0 + i);
            vpos       = 10'(v);
            display_on = 1'b1;
            hsync_in   = 1'b0;
            vsync_in   = 1'b0;
            e.chk = 1'b1; e.rgb = 12'h000; e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
            e.mode = 2'd0; e.name = "reset";
            sb_q.push_back(e);
        end
    endtask

    // Drive consecutive pixels h0..h1 of line v. Pixels matching the head of
    // the checkpoint queue are checked.
    task automatic run_line(input int v, input int h0, input int h1, input int de_mode);
        for (int h = h0; h <= h1; h++) begin
            exp_t e;
            cp_t  c;
            logic de;
            logic hs;
            logic vs;
            de = (de_mode == DE_ON) ? 1'b1 :
                 (de_mode == DE_OFF) ? 1'b0 : logic'((h < 640) && (v < 480));
            hs = !((h >= 656) && (h < 752));
            vs = !((v >= 490) && (v < 492));
            @(negedge clk);
            reset      = 1'b0;
            hpos       = 10'(h);
            vpos       = 10'(v);
            display_on = de;
            hsync_in   = hs;
            vsync_in   = vs;
            if (h == sw_h) mode_sel = sw_mode;
            e.chk = 1'b0; e.rgb = 12'h000; e.de = de; e.hs = hs; e.vs = vs;
            e.mode = 2'd0; e.name = "";
            if (cp_q.size() > 0 && cp_q[0].h == h) begin
                c = cp_q.pop_front();
                e.chk = 1'b1; e.rgb = c.rgb; e.mode = c.mode; e.name = c.name;
            end
            sb_q.push_back(e);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        mode_sel   = 2'd2;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        display_on = 1'b0;
        hpos       = '0;
        vpos       = '0;

        // Reset mid-line with live inputs
        reset_pix(5, 100, 3);
        mode_sel = 2'd0;

        // Mode 0 bars, line 10, including hsync propagation
        cp(0,   12'hFFF, 2'd0, "bars_h0");
        cp(79,  12'hFFF, 2'd0, "bars_h79");
        cp(80,  12'hFF0, 2'd0, "bars_h80");
        cp(160, 12'hF0F, 2'd0, "bars_h160");
        cp(240, 12'hF00, 2'd0, "bars_h240");
        cp(559, 12'h00F, 2'd0, "bars_h559");
        cp(560, 12'h000, 2'd0, "bars_h560");
        cp(639, 12'h000, 2'd0, "bars_h639");
        cp(640, 12'h000, 2'd0, "bars_h640");
        cp(657, 12'h000, 2'd0, "bars_hsync");
        run_line(10, 0, 660, DE_NORMAL);

        // vpos beyond active area blanks even with display_on forced high
        cp(0, 12'h000, 2'd0, "vblank_de_on");
        run_line(485, 0, 2, DE_ON);
        cp(1, 12'h000, 2'd0, "vsync_low");
        run_line(490, 0, 2, DE_NORMAL);

        // Mode 2 gradient
        mode_sel = 2'd2;
        cp(0, 12'h000, 2'd2, "grad_frame_start");
        run_line(0, 0, 0, DE_NORMAL);
        cp(0,   12'h000, 2'd2, "grad_h0");
        cp(39,  12'h000, 2'd2, "grad_h39");
        cp(40,  12'h111, 2'd2, "grad_h40");
        cp(320, 12'h888, 2'd2, "grad_h320");
        cp(639, 12'hFFF, 2'd2, "grad_h639");
        cp(640, 12'h000, 2'd2, "grad_h640_de_on");
        run_line(20, 0, 642, DE_ON);
        cp(5, 12'h000, 2'd2, "grad_de_off");
        run_line(21, 0, 8, DE_OFF);

        // Mode 1 checker
        mode_sel = 2'd1;
        cp(0,  12'h000, 2'd1, "chk_0_0");
        cp(32, 12'hFFF, 2'd1, "chk_32_0");
        run_line(0, 0, 34, DE_NORMAL);
        cp(31, 12'hFFF, 2'd1, "chk_31_32");
        cp(32, 12'h000, 2'd1, "chk_32_32");
        run_line(32, 0, 34, DE_NORMAL);

        // Reset mid-line; next line resumes in mode 0 although mode_sel is 1
        run_line(40, 0, 100, DE_NORMAL);
        reset_pix(40, 101, 3);
        run_line(40, 104, 120, DE_NORMAL);
        cp(0,  12'hFFF, 2'd0, "rst_resume_h0");
        cp(80, 12'hFF0, 2'd0, "rst_resume_h80");
        run_line(41, 0, 81, DE_NORMAL);

        // Mid-frame mode_sel change is deferred to the next frame start
        mode_sel = 2'd0;
        cp(0, 12'hFFF, 2'd0, "bars_frame");
        run_line(0, 0, 0, DE_NORMAL);
        sw_h    = 300;
        sw_mode = 2'd1;
        cp(320, 12'h0FF, 2'd0, "switch_ignored");
        run_line(200, 0, 322, DE_NORMAL);
        sw_h = -1;
        cp(0, 12'hFFF, 2'd0, "switch_next_line");
        run_line(201, 0, 1, DE_NORMAL);
        cp(0,  12'h000, 2'd1, "switch_frame_0_0");
        cp(32, 12'hFFF, 2'd1, "switch_frame_32_0");
        run_line(0, 0, 33, DE_NORMAL);

        // Mode 3 scrolling from a clean frame counter
        reset_pix(50, 10, 2);
        mode_sel = 2'd3;
        for (int f = 1; f <= 15; f++) begin
            cp(0, 12'hFFF, 2'd3, $sformatf("scroll_f%0d_h0", f));
            run_line(0, 0, 0, DE_NORMAL);
        end
        run_line(0, 0, 0, DE_NORMAL);        // frame 16: scroll index steps
        run_line(1, 0, 0, DE_NORMAL);
        cp(0,   12'hFF0, 2'd3, "scroll_f17_h0");
        cp(80,  12'hF0F, 2'd3, "scroll_f17_h80");
        cp(560, 12'hFFF, 2'd3, "scroll_f17_h560");
        run_line(0, 0, 562, DE_NORMAL);
        cp(0, 12'hFF0, 2'd3, "scroll_f17_line1");
        run_line(1, 0, 0, DE_NORMAL);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("checkpoints_consumed", 32'(cp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
